// File: rtl/gcd_pkg.sv
// Shared types and sizing for the GCD reduction controller.
package gcd_pkg;

    localparam int GCD_W = 32;
    localparam int GCD_N = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gcd_state_e;

endpackage

// File: rtl/nz_single_detect.sv
// Combinational termination test: flags all-zero, exactly-one-nonzero, and
// the index of the nonzero operand.
import gcd_pkg::*;

module nz_single_detect #(
    parameter int W = GCD_W
) (
    input  logic [GCD_N-1:0][W-1:0] v_i,
    output logic                    single_o,
    output logic                    none_o,
    output logic [1:0]              idx_o
);

    logic [GCD_N-1:0] nz;

    // idx_o is only meaningful when single_o is set, so which nonzero wins is irrelevant.
    always_comb begin
        nz    = '0;
        idx_o = '0;
        for (int i = 0; i < GCD_N; i++) begin
            nz[i] = |v_i[i];
            if (nz[i]) idx_o = 2'(i);
        end
    end

    assign none_o   = ~|nz;
    assign single_o = $onehot(nz);

endmodule

// File: rtl/gcd_reduce_ctrl.sv
// Iterative subtract-reduction of four operands down to their GCD.
// Optional step limit enabled by defining GCD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one subtract step per cycle until a single nonzero survives
import gcd_pkg::*;

module gcd_reduce_ctrl #(
    parameter int W        = GCD_W,
    parameter int MAX_ITER = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a_in0,
    input  logic [W-1:0] a_in1,
    input  logic [W-1:0] a_in2,
    input  logic [W-1:0] a_in3,
    output logic         busy,
    output logic         done,
    output logic [1:0]   idx,
    output logic [W-1:0] value,
    output logic         err
);

    gcd_state_e              state_q, state_d;
    logic [GCD_N-1:0][W-1:0] r_q, r_d, r_step;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [1:0]              idx_q, idx_d;
    logic [W-1:0]            value_q, value_d;

    logic                    det_single, det_none;
    logic [1:0]              det_idx;
    logic [W-1:0]            m;
    logic [1:0]              keeper;
    logic                    found;

`ifdef GCD_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_ITER + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_max_iter;
    assign unused_max_iter = 32'(MAX_ITER);
`endif

    nz_single_detect #(.W(W)) u_detect (
        .v_i      (r_q),
        .single_o (det_single),
        .none_o   (det_none),
        .idx_o    (det_idx)
    );

    // Strict compare keeps the lowest index among equal minima as keeper.
    always_comb begin
        m      = '1;
        keeper = '0;
        found  = 1'b0;
        for (int i = 0; i < GCD_N; i++) begin
            if ((|r_q[i]) && (!found || (r_q[i] < m))) begin
                m      = r_q[i];
                keeper = 2'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < GCD_N; i++) begin
            if ((|r_q[i]) && (2'(i) != keeper)) r_step[i] = r_q[i] - m;
            else                               r_step[i] = r_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        done_d  = 1'b0;
        err_d   = err_q;
        idx_d   = idx_q;
        value_d = value_q;
`ifdef GCD_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    r_d     = {a_in3, a_in2, a_in1, a_in0};
                    err_d   = 1'b0;
                    idx_d   = '0;
                    value_d = '0;
`ifdef GCD_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                if (det_none) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    idx_d   = '0;
                    value_d = '0;
                    state_d = IDLE;
                end else if (det_single) begin
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    idx_d   = det_idx;
                    value_d = r_q[det_idx];
                    state_d = IDLE;
`ifdef GCD_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(MAX_ITER)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    idx_d   = '0;
                    value_d = '0;
                    state_d = IDLE;
`endif
                end else begin
                    r_d     = r_step;
`ifdef GCD_TIMEOUT_EN
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            value_q <= value_d;
        end
    end

`ifdef GCD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign err   = err_q;
    assign idx   = idx_q;
    assign value = value_q;

endmodule
